// File: rtl/vdc_blkop.sv
// vdc_blkop: CPU-side access engine for the VDC video RAM.
// Handles update-address writes, R31 data reads/writes, and the 8563
// block fill / block copy operations. The engine owns the RAM only in
// cycles with slot=1; the RAM registers its address internally, so read
// data appears on ram_din one cycle after the issuing slot cycle.
// Optional feature: define VDC_PREFETCH_EN to prefetch the byte at the
// update address into data_out after every address load and increment.
module vdc_blkop #(
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     upd_addr_we,
  input  logic [15:0]              upd_addr_in,
  input  logic                     src_addr_we,
  input  logic [15:0]              src_addr_in,
  input  logic                     copy,
  input  logic                     data_we,
  input  logic [7:0]               data_in,
  input  logic                     data_rd,
  input  logic                     count_we,
  input  logic [7:0]               count_in,
  input  logic                     slot,
  input  logic [7:0]               ram_din,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_we,
  output logic [7:0]               ram_dout,
  output logic [7:0]               data_out,
  output logic [15:0]              upd_addr,
  output logic [15:0]              src_addr,
  output logic                     busy
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISS,
    RD_CAP,
    FILL,
    CP_RD,
    CP_CAP,
    CP_WR
  } state_t;

  state_t      state;
  logic [7:0]  fill_byte;
  logic [8:0]  remaining;   // 1..256 while a block op runs
  logic [15:0] addr_sel;

  // RAM address and write strobe follow the current state; the write must
  // be qualified by this cycle's slot, so it cannot be a registered output.
  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    addr_sel = upd_addr;
    ram_we   = 1'b0;
    case (state)
      CP_RD:           addr_sel = src_addr;
      WR, FILL, CP_WR: ram_we   = slot;
      default:         ;
    endcase
  end

  assign ram_addr = addr_sel[ADDRESS_WIDTH-1:0];

  // Main FSM: command decode in IDLE, RAM access sequencing elsewhere.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register sees pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      ram_dout  <= 8'h00;
      data_out  <= 8'h00;
      upd_addr  <= 16'h0000;
      src_addr  <= 16'h0000;
      fill_byte <= 8'h00;
      remaining <= 9'd0;
    end else begin
      case (state)
        IDLE: begin
          // Address loads run alongside whichever command strobe wins.
          if (upd_addr_we) upd_addr <= upd_addr_in;
          if (src_addr_we) src_addr <= src_addr_in;
          if (count_we) begin
            remaining <= (count_in == 8'd0) ? 9'd256 : {1'b0, count_in};
            busy      <= 1'b1;
            if (copy) begin
              state <= CP_RD;
            end else begin
              state    <= FILL;
              ram_dout <= fill_byte;
            end
          end else if (data_we) begin
            fill_byte <= data_in;
            ram_dout  <= data_in;
            state     <= WR;
            busy      <= 1'b1;
          end else if (data_rd) begin
`ifdef VDC_PREFETCH_EN
            // data_out already holds this byte; step past it and refetch.
            upd_addr <= (upd_addr_we ? upd_addr_in : upd_addr) + 16'd1;
`endif
            state <= RD_ISS;
            busy  <= 1'b1;
          end
`ifdef VDC_PREFETCH_EN
          else if (upd_addr_we) begin
            state <= RD_ISS;
            busy  <= 1'b1;
          end
`endif
        end

        WR: begin
          if (slot) begin
            data_out <= ram_dout;
            upd_addr <= upd_addr + 16'd1;
`ifdef VDC_PREFETCH_EN
            state    <= RD_ISS;
`else
            state    <= IDLE;
            busy     <= 1'b0;
`endif
          end
        end

        RD_ISS: begin
          if (slot) state <= RD_CAP;
        end

        RD_CAP: begin
          // Read data is valid this cycle regardless of slot.
          data_out <= ram_din;
`ifndef VDC_PREFETCH_EN
          upd_addr <= upd_addr + 16'd1;
`endif
          state    <= IDLE;
          busy     <= 1'b0;
        end

        FILL: begin
          if (slot) begin
            upd_addr  <= upd_addr + 16'd1;
            remaining <= remaining - 9'd1;
            if (remaining == 9'd1) begin
              data_out <= ram_dout;
              state    <= IDLE;
              busy     <= 1'b0;
            end
          end
        end

        CP_RD: begin
          if (slot) state <= CP_CAP;
        end

        CP_CAP: begin
          ram_dout <= ram_din;
          state    <= CP_WR;
        end

        CP_WR: begin
          if (slot) begin
            upd_addr  <= upd_addr + 16'd1;
            src_addr  <= src_addr + 16'd1;
            remaining <= remaining - 9'd1;
            if (remaining == 9'd1) begin
              data_out <= ram_dout;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              state <= CP_RD;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vdc_blkop.sv
// tb_vdc_blkop: self-checking bench for vdc_blkop (default build).
// A bench-side RAM (registered address, slot-qualified) sits behind the DUT.
// The model predicts the exact ordered list of RAM writes plus the final
// register values of each CPU operation; a monitor compares every write.
module tb_vdc_blkop;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        upd_addr_we = 1'b0;
  logic [15:0] upd_addr_in = 16'h0;
  logic        src_addr_we = 1'b0;
  logic [15:0] src_addr_in = 16'h0;
  logic        copy = 1'b0;
  logic        data_we = 1'b0;
  logic [7:0]  data_in = 8'h0;
  logic        data_rd = 1'b0;
  logic        count_we = 1'b0;
  logic [7:0]  count_in = 8'h0;
  logic        slot = 1'b1;
  logic [7:0]  ram_din;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic [7:0]  data_out;
  logic [15:0] upd_addr;
  logic [15:0] src_addr;
  logic        busy;

  vdc_blkop #(.ADDRESS_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .upd_addr_we(upd_addr_we), .upd_addr_in(upd_addr_in),
    .src_addr_we(src_addr_we), .src_addr_in(src_addr_in),
    .copy(copy), .data_we(data_we), .data_in(data_in), .data_rd(data_rd),
    .count_we(count_we), .count_in(count_in), .slot(slot), .ram_din(ram_din),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_dout(ram_dout),
    .data_out(data_out), .upd_addr(upd_addr), .src_addr(src_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slot pattern: always 1, or the repeating 1,0,0 pattern.
  bit slot_toggle = 1'b0;
  int slot_phase = 0;
  always @(posedge clk) begin
    #1;
    if (slot_toggle) begin
      slot = (slot_phase == 0);
      slot_phase = (slot_phase + 1) % 3;
    end else begin
      slot = 1'b1;
      slot_phase = 0;
    end
  end

  // Video RAM: address registered on slot cycles; when the previous cycle
  // belonged to video fetch, q shows unrelated data.
  logic [7:0]  ram [0:65535];
  logic [15:0] q_addr = 16'h0;
  logic        q_valid = 1'b0;
  always @(posedge clk) begin
    if (slot) begin
      if (ram_we) ram[ram_addr] <= ram_dout;
      q_addr <= ram_addr;
    end
    q_valid <= slot;
  end
  assign ram_din = q_valid ? ram[q_addr] : 8'hEE;

  // Model state: expected write stream and architectural registers.
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;
  wr_t         exp_q[$];
  logic [7:0]  model_mem [0:65535];
  logic [15:0] m_upd = 16'h0;
  logic [15:0] m_src = 16'h0;
  logic [7:0]  m_fill = 8'h0;
  logic [7:0]  m_dout = 8'h0;
  int          wr_count = 0;

  // Compare process: every cycle, every RAM write against the model stream.
  always @(negedge clk) begin
    check("we_without_slot", {31'd0, ram_we & ~slot}, 32'd0);
    if (ram_we) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {16'd0, ram_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {16'd0, ram_addr}, {16'd0, e.addr});
        check("wr_data", {24'd0, ram_dout}, {24'd0, e.data});
        model_mem[e.addr] = e.data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic wait_idle(input int budget, input string name, output int busy_cycles);
    busy_cycles = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      busy_cycles++;
      if (busy_cycles > budget) begin
        check({name, "_timeout"}, 32'd1, 32'd0);
        break;
      end
    end
  endtask

  task automatic load_upd(input logic [15:0] a);
    @(posedge clk); #1;
    upd_addr_we = 1'b1; upd_addr_in = a;
    @(posedge clk); #1;
    upd_addr_we = 1'b0;
    m_upd = a;
  endtask

  task automatic load_src(input logic [15:0] a);
    @(posedge clk); #1;
    src_addr_we = 1'b1; src_addr_in = a;
    @(posedge clk); #1;
    src_addr_we = 1'b0;
    m_src = a;
  endtask

  task automatic cpu_write(input logic [7:0] d, output int busy_cycles);
    exp_q.push_back('{addr: m_upd, data: d});
    m_upd++; m_fill = d; m_dout = d;
    @(posedge clk); #1;
    data_we = 1'b1; data_in = d;
    @(posedge clk); #1;
    data_we = 1'b0;
    wait_idle(20, "cpu_write", busy_cycles);
  endtask

  task automatic cpu_read(input logic [7:0] lit, input string name);
    int bc;
    logic [7:0] e;
    e = model_mem[m_upd];
    m_upd++; m_dout = e;
    @(posedge clk); #1;
    data_rd = 1'b1;
    @(posedge clk); #1;
    data_rd = 1'b0;
    wait_idle(20, name, bc);
    check({name, "_data"}, {24'd0, data_out}, {24'd0, e});
    check({name, "_lit"}, {24'd0, data_out}, {24'd0, lit});
    check({name, "_upd"}, {16'd0, upd_addr}, {16'd0, m_upd});
  endtask

  // Predict the write stream of a block op, then pulse count_we.
  task automatic start_block(input logic [7:0] cnt, input logic cp);
    int n;
    logic [7:0] d;
    n = (cnt == 8'd0) ? 256 : int'(cnt);
    for (int i = 0; i < n; i++) begin
      d = cp ? model_mem[m_src] : m_fill;
      exp_q.push_back('{addr: m_upd, data: d});
      m_upd++;
      if (cp) m_src++;
      m_dout = d;
    end
    @(posedge clk); #1;
    count_we = 1'b1; count_in = cnt; copy = cp;
    @(posedge clk); #1;
    count_we = 1'b0; copy = 1'b0;
  endtask

  task automatic check_regs(input string name);
    check({name, "_upd"}, {16'd0, upd_addr}, {16'd0, m_upd});
    check({name, "_src"}, {16'd0, src_addr}, {16'd0, m_src});
    check({name, "_dout"}, {24'd0, data_out}, {24'd0, m_dout});
    check({name, "_pending"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_we"}, {31'd0, ram_we}, 32'd0);
    check({name, "_addr"}, {16'd0, ram_addr}, 32'd0);
    check({name, "_rdout"}, {24'd0, ram_dout}, 32'd0);
    check({name, "_dout"}, {24'd0, data_out}, 32'd0);
    check({name, "_upd"}, {16'd0, upd_addr}, 32'd0);
    check({name, "_src"}, {16'd0, src_addr}, 32'd0);
  endtask

  initial begin
    int bc;
    int base;
    int guard;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    // Single write at 0x1000: one write, busy for exactly one cycle
    load_upd(16'h1000);
    base = wr_count;
    cpu_write(8'hA5, bc);
    check("wr1_busy_cycles", bc, 32'd1);
    check("wr1_count", wr_count - base, 32'd1);
    check("wr1_upd_lit", {16'd0, upd_addr}, 32'h1001);
    check_regs("wr1");

    // Read it back
    load_upd(16'h1000);
    cpu_read(8'hA5, "rd1");

    // Fill of 256 bytes starting after a write at 0x0000
    load_upd(16'h0000);
    cpu_write(8'h20, bc);
    base = wr_count;
    start_block(8'h00, 1'b0);
    wait_idle(2000, "fill256", bc);
    check("fill256_count", wr_count - base, 32'd256);
    check("fill256_upd_lit", {16'd0, upd_addr}, 32'h0101);
    check("fill256_dout_lit", {24'd0, data_out}, 32'h20);
    check_regs("fill256");

    // Copy three bytes 0x2000 -> 0x3000
    load_upd(16'h2000);
    cpu_write(8'h11, bc);
    cpu_write(8'h22, bc);
    cpu_write(8'h33, bc);
    load_src(16'h2000);
    load_upd(16'h3000);
    base = wr_count;
    start_block(8'd3, 1'b1);
    wait_idle(100, "copy3", bc);
    check("copy3_count", wr_count - base, 32'd3);
    check("copy3_src_lit", {16'd0, src_addr}, 32'h2003);
    check("copy3_dout_lit", {24'd0, data_out}, 32'h33);
    check_regs("copy3");
    load_upd(16'h3000);
    cpu_read(8'h11, "copy3_rb0");
    cpu_read(8'h22, "copy3_rb1");
    cpu_read(8'h33, "copy3_rb2");

    // Slot toggling 1,0,0: fill of 4 and copy of 2
    slot_toggle = 1'b1;
    load_upd(16'h5000);
    cpu_write(8'h66, bc);
    base = wr_count;
    start_block(8'd4, 1'b0);
    wait_idle(100, "fill4_slot", bc);
    check("fill4_slot_count", wr_count - base, 32'd4);
    check("fill4_slot_upd_lit", {16'd0, upd_addr}, 32'h5005);
    check_regs("fill4_slot");
    load_src(16'h2001);
    load_upd(16'h6000);
    start_block(8'd2, 1'b1);
    wait_idle(100, "copy2_slot", bc);
    check_regs("copy2_slot");
    load_upd(16'h6000);
    cpu_read(8'h22, "copy2_rb0");
    cpu_read(8'h33, "copy2_rb1");
    slot_toggle = 1'b0;

    // Address wrap
    load_upd(16'hFFFF);
    cpu_write(8'h5A, bc);
    check("wrap_upd_lit", {16'd0, upd_addr}, 32'h0000);
    check_regs("wrap");

    // Same-cycle address load and write: write uses the new address
    exp_q.push_back('{addr: 16'h4000, data: 8'h3C});
    m_upd = 16'h4001; m_fill = 8'h3C; m_dout = 8'h3C;
    @(posedge clk); #1;
    upd_addr_we = 1'b1; upd_addr_in = 16'h4000; data_we = 1'b1; data_in = 8'h3C;
    @(posedge clk); #1;
    upd_addr_we = 1'b0; data_we = 1'b0;
    wait_idle(20, "prio", bc);
    check_regs("prio");

    // Strobes while busy are ignored
    start_block(8'd4, 1'b0);
    upd_addr_we = 1'b1; upd_addr_in = 16'h9999;
    data_we = 1'b1; data_in = 8'hFF; count_we = 1'b1; count_in = 8'd9;
    @(posedge clk); #1;
    upd_addr_we = 1'b0; data_we = 1'b0; count_we = 1'b0;
    wait_idle(100, "busy_ign", bc);
    check("busy_ign_upd_lit", {16'd0, upd_addr}, 32'h4005);
    check_regs("busy_ign");

    // Reset in the middle of an 8-byte fill, during the third write
    load_upd(16'h7000);
    cpu_write(8'h77, bc);
    base = wr_count;
    start_block(8'd8, 1'b0);
    guard = 0;
    while ((wr_count - base) < 2 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    check("midreset_reach", {31'd0, guard >= 50}, 32'd0);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_count", wr_count - base, 32'd3);
    check_reset_values("midreset");
    reset = 1'b0;
    exp_q.delete();
    m_upd = 16'h0; m_src = 16'h0; m_fill = 8'h0; m_dout = 8'h0;
    repeat (4) @(negedge clk);
    check("midreset_after_count", wr_count - base, 32'd3);
    check("midreset_after_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
